// File: rtl/ss_count_monitor.sv
// Lock monitor for a free-running FIRST..LAST counter: acquires lock after
// LOCK_CNT consecutive correct steps, then flags wraps, losses and bad samples.
module ss_count_monitor #(
  parameter int WIDTH    = 4,
  parameter int FIRST    = 0,
  parameter int LAST     = 15,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count,
  input  logic             clr_err,
  output logic             locked,
  output logic             wrap,
  output logic             lost,
  output logic             illegal,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       dbg_state_o
);

  localparam int RUN_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] FIRST_V = WIDTH'(FIRST);
  localparam logic [WIDTH-1:0] LAST_V  = WIDTH'(LAST);
  localparam logic [RUN_W-1:0] LOCK_V  = RUN_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               wrap_q, wrap_d;
  logic               lost_q, lost_d;
  logic               illegal_q, illegal_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               above_first, below_last, legal;
  logic [WIDTH-1:0]   exp_val;
  logic               match;
  logic [RUN_W-1:0]   run_inc;

  // Range bounds that span the whole bus collapse to constants, avoiding
  // always-true comparisons.
  if (FIRST == 0) begin : g_lo_open
    assign above_first = 1'b1;
  end else begin : g_lo_cmp
    assign above_first = (count >= FIRST_V);
  end

  if (LAST == (1 << WIDTH) - 1) begin : g_hi_open
    assign below_last = 1'b1;
  end else begin : g_hi_cmp
    assign below_last = (count <= LAST_V);
  end

  assign legal   = above_first & below_last;
  assign exp_val = (prev_q == LAST_V) ? FIRST_V : prev_q + WIDTH'(1);
  assign match   = legal && (count == exp_val);
  assign run_inc = run_q + RUN_W'(1);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      run_q     <= '0;
      wrap_q    <= 1'b0;
      lost_q    <= 1'b0;
      illegal_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= count;
      run_q     <= run_d;
      wrap_q    <= wrap_d;
      lost_q    <= lost_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_ACQUIRE;
        run_d   = '0;
      end
      ST_ACQUIRE: begin
        if (match) begin
          if (run_inc == LOCK_V) begin
            state_d = ST_LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          run_d = '0;
        end
      end
      ST_LOCKED: begin
        if (!match) begin
          state_d = ST_ACQUIRE;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
      end
    endcase
  end

  // Output logic: next values of the registered pulses and error tally.
  always_comb begin
    wrap_d    = (state_q == ST_LOCKED) && match &&
                (prev_q == LAST_V) && (count == FIRST_V);
    lost_d    = (state_q == ST_LOCKED) && !match;
    illegal_d = (state_q != ST_IDLE) && !legal;
    err_d     = err_q;
    if (clr_err) begin
      err_d = '0;
    end else if (lost_d && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  assign locked      = (state_q == ST_LOCKED);
  assign wrap        = wrap_q;
  assign lost        = lost_q;
  assign illegal     = illegal_q;
  assign err_cnt     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ss_count_monitor.sv
// Bench for ss_count_monitor: vector table, corner sequences on two parameter
// variants, and a randomized run against a behavioural model of the rules.
module tb_ss_count_monitor;

  logic       clk;
  logic       rst_n;
  logic [3:0] count;
  logic       clr_err;

  logic       l0, w0, ls0, il0;
  logic [7:0] e0;
  logic [1:0] s0;
  logic       l1, w1, ls1, il1;
  logic [7:0] e1;
  logic [1:0] s1;
  logic       l2, w2, ls2, il2;
  logic [1:0] e2;
  logic [1:0] s2;

  int n_checks = 0;
  int n_fail   = 0;

  ss_count_monitor dut0 (
    .clk(clk), .rst_n(rst_n), .count(count), .clr_err(clr_err),
    .locked(l0), .wrap(w0), .lost(ls0), .illegal(il0), .err_cnt(e0),
    .dbg_state_o(s0)
  );

  ss_count_monitor #(.FIRST(2), .LAST(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .count(count), .clr_err(clr_err),
    .locked(l1), .wrap(w1), .lost(ls1), .illegal(il1), .err_cnt(e1),
    .dbg_state_o(s1)
  );

  ss_count_monitor #(.ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .count(count), .clr_err(clr_err),
    .locked(l2), .wrap(w2), .lost(ls2), .illegal(il2), .err_cnt(e2),
    .dbg_state_o(s2)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checking helpers
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input int c, input logic clr);
    rst_n   = r;
    count   = 4'(c);
    clr_err = clr;
    step();
  endtask

  // Vector table for the default instance
  typedef struct {
    logic       r;
    logic [3:0] c;
    logic       clr;
    logic       lk;
    logic       wr;
    logic       ls;
    logic       il;
    logic [7:0] err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input int c, input logic clr,
                     input logic lk, input logic wr, input logic ls,
                     input logic il, input int err);
    vec_t v;
    v.r = r; v.c = 4'(c); v.clr = clr;
    v.lk = lk; v.wr = wr; v.ls = ls; v.il = il; v.err = 8'(err);
    tbl.push_back(v);
  endtask

  // Behavioural reference model, one slot per instance
  int m_first[3]  = '{0, 2, 0};
  int m_last[3]   = '{15, 12, 15};
  int m_errmax[3] = '{255, 255, 3};
  int m_prev[3], m_streak[3], m_err[3];
  bit m_have[3], m_lk[3], m_wr[3], m_ls[3], m_il[3];

  task automatic model_step(input int i, input logic r, input int c, input logic clr);
    bit ok_range, good;
    int nxt;
    m_wr[i] = 0; m_ls[i] = 0; m_il[i] = 0;
    if (!r) begin
      m_have[i] = 0; m_lk[i] = 0; m_streak[i] = 0; m_err[i] = 0; m_prev[i] = 0;
      return;
    end
    ok_range = (c >= m_first[i]) && (c <= m_last[i]);
    nxt = (m_prev[i] == m_last[i]) ? m_first[i] : (m_prev[i] + 1) % 16;
    good = ok_range && (c == nxt);
    if (!m_have[i]) begin
      m_have[i] = 1;
      m_streak[i] = 0;
    end else begin
      m_il[i] = !ok_range;
      if (m_lk[i]) begin
        if (good) begin
          m_wr[i] = (m_prev[i] == m_last[i]) && (c == m_first[i]);
        end else begin
          m_ls[i] = 1;
          m_lk[i] = 0;
          m_streak[i] = 0;
          if (m_err[i] < m_errmax[i]) m_err[i]++;
        end
      end else if (good) begin
        m_streak[i]++;
        if (m_streak[i] == 3) begin
          m_lk[i] = 1;
          m_streak[i] = 0;
        end
      end else begin
        m_streak[i] = 0;
      end
    end
    if (clr) m_err[i] = 0;
    m_prev[i] = c;
  endtask

  task automatic check_model(input int i, input int cyc);
    int a_lk, a_wr, a_ls, a_il, a_err;
    case (i)
      0:       begin a_lk = l0; a_wr = w0; a_ls = ls0; a_il = il0; a_err = int'(e0); end
      1:       begin a_lk = l1; a_wr = w1; a_ls = ls1; a_il = il1; a_err = int'(e1); end
      default: begin a_lk = l2; a_wr = w2; a_ls = ls2; a_il = il2; a_err = int'(e2); end
    endcase
    chk($sformatf("rnd%0d dut%0d locked", cyc, i), a_lk, int'(m_lk[i]));
    chk($sformatf("rnd%0d dut%0d wrap", cyc, i), a_wr, int'(m_wr[i]));
    chk($sformatf("rnd%0d dut%0d lost", cyc, i), a_ls, int'(m_ls[i]));
    chk($sformatf("rnd%0d dut%0d illegal", cyc, i), a_il, int'(m_il[i]));
    chk($sformatf("rnd%0d dut%0d err_cnt", cyc, i), a_err, m_err[i]);
  endtask

  initial begin
    int bads[5]  = '{9, 0, 9, 0, 9};
    int exp2[5]  = '{1, 2, 3, 3, 0};
    int exp0[5]  = '{1, 2, 3, 4, 0};
    int cur;
    bit mode;
    logic r, clr;
    int c;

    rst_n = 1'b0; count = '0; clr_err = 1'b0;

    // Table: lock-in, loss/recovery, wrap, clear behaviour, mid-run reset
    add(0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 0, 0,  0, 0, 0, 0, 0);
    add(1, 1, 0,  0, 0, 0, 0, 0);
    add(1, 2, 0,  0, 0, 0, 0, 0);
    add(1, 3, 0,  1, 0, 0, 0, 0);
    add(1, 4, 0,  1, 0, 0, 0, 0);
    add(1, 5, 0,  1, 0, 0, 0, 0);
    add(1, 9, 0,  0, 0, 1, 0, 1);
    add(1, 10, 0, 0, 0, 0, 0, 1);
    add(1, 11, 0, 0, 0, 0, 0, 1);
    add(1, 12, 0, 1, 0, 0, 0, 1);
    add(1, 13, 0, 1, 0, 0, 0, 1);
    add(1, 14, 0, 1, 0, 0, 0, 1);
    add(1, 15, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0,  1, 1, 0, 0, 1);
    add(1, 1, 0,  1, 0, 0, 0, 1);
    add(1, 2, 0,  1, 0, 0, 0, 1);
    add(1, 3, 1,  1, 0, 0, 0, 0);
    add(1, 9, 0,  0, 0, 1, 0, 1);
    add(1, 10, 0, 0, 0, 0, 0, 1);
    add(1, 11, 0, 0, 0, 0, 0, 1);
    add(1, 12, 0, 1, 0, 0, 0, 1);
    add(1, 7, 1,  0, 0, 1, 0, 0);
    add(1, 15, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0,  0, 0, 0, 0, 0);
    add(1, 1, 0,  0, 0, 0, 0, 0);
    add(1, 2, 0,  1, 0, 0, 0, 0);
    add(1, 6, 0,  0, 0, 1, 0, 1);
    add(1, 7, 0,  0, 0, 0, 0, 1);
    add(1, 8, 0,  0, 0, 0, 0, 1);
    add(1, 9, 0,  1, 0, 0, 0, 1);
    add(0, 10, 0, 0, 0, 0, 0, 0);
    add(1, 3, 0,  0, 0, 0, 0, 0);
    add(1, 4, 0,  0, 0, 0, 0, 0);
    add(1, 5, 0,  0, 0, 0, 0, 0);
    add(1, 6, 0,  1, 0, 0, 0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].r, int'(tbl[k].c), tbl[k].clr);
      chk($sformatf("vec%0d locked", k), l0, tbl[k].lk);
      chk($sformatf("vec%0d wrap", k), w0, tbl[k].wr);
      chk($sformatf("vec%0d lost", k), ls0, tbl[k].ls);
      chk($sformatf("vec%0d illegal", k), il0, tbl[k].il);
      chk($sformatf("vec%0d err_cnt", k), int'(e0), int'(tbl[k].err));
    end

    // Narrow range instance: idle ignores range, illegal counts as loss
    drive(0, 0, 0);
    drive(1, 0, 0);  chk("r212 idle illegal", il1, 0);
    drive(1, 2, 0);  chk("r212 acq lock", l1, 0);
    drive(1, 3, 0);
    drive(1, 4, 0);  chk("r212 before lock", l1, 0);
    drive(1, 5, 0);  chk("r212 locked", l1, 1);
    drive(1, 6, 0);
    drive(1, 13, 0);
    chk("r212 oor illegal", il1, 1);
    chk("r212 oor lost", ls1, 1);
    chk("r212 oor err", int'(e1), 1);
    chk("r212 oor locked", l1, 0);
    drive(1, 14, 0);
    chk("r212 acq illegal", il1, 1);
    chk("r212 acq no lost", ls1, 0);
    drive(1, 9, 0);  chk("r212 back in range", il1, 0);
    drive(1, 10, 0);
    drive(1, 11, 0);
    drive(1, 12, 0); chk("r212 relock", l1, 1); chk("r212 no wrap at last", w1, 0);
    drive(1, 2, 0);  chk("r212 wrap", w1, 1);
    drive(1, 3, 0);  chk("r212 wrap ends", w1, 0);

    // Narrow error counter: saturation, then clear coinciding with a loss
    drive(0, 0, 0);
    drive(1, 0, 0);
    drive(1, 1, 0);
    drive(1, 2, 0);
    drive(1, 3, 0);  chk("sat locked", l2, 1);
    for (int k = 0; k < 5; k++) begin
      drive(1, bads[k], k == 4);
      chk($sformatf("sat loss%0d lost", k), ls2, 1);
      chk($sformatf("sat loss%0d err2", k), int'(e2), exp2[k]);
      chk($sformatf("sat loss%0d err8", k), int'(e0), exp0[k]);
      chk($sformatf("sat loss%0d locked", k), l2, 0);
      if (k < 4) begin
        drive(1, bads[k] + 1, 0);
        chk($sformatf("sat loss%0d pulse", k), ls2, 0);
        drive(1, bads[k] + 2, 0);
        drive(1, bads[k] + 3, 0);
        chk($sformatf("sat relock%0d", k), l2, 1);
      end
    end

    // Randomized run against the model
    for (int i = 0; i < 3; i++) model_step(i, 1'b0, 0, 1'b0);
    drive(0, 0, 0);
    cur = 0;
    mode = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 250 == 0) mode = ~mode;
      if ($urandom_range(0, 99) < 8) c = int'($urandom_range(0, 15));
      else if (mode) c = (cur >= 12 || cur < 2) ? 2 : cur + 1;
      else c = (cur + 1) % 16;
      clr = ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 199) != 0);
      cur = c;
      for (int i = 0; i < 3; i++) model_step(i, r, c, clr);
      drive(r, c, clr);
      for (int i = 0; i < 3; i++) check_model(i, cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
